// File: rtl/sweep_ctrl_pkg.sv
// Shared definitions for the sweep controller and the up/down counter it drives.
package sweep_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_UP        = 3'd1;
  localparam state_t ST_DWELL_TOP = 3'd2;
  localparam state_t ST_DOWN      = 3'd3;
  localparam state_t ST_DWELL_BOT = 3'd4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Direction is a pure function of state; dwell states point toward the next leg.
  function automatic logic state_dir(input state_t st);
    return (st == ST_DOWN || st == ST_DWELL_TOP) ? DIR_DOWN : DIR_UP;
  endfunction

endpackage

// File: rtl/sweep_ctrl_dwell_timer.sv
// Loadable down-counter with zero flag, used to hold the sweep at each turn-around.
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero
);

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle-sweep controller: steers an external up/down counter between latched limits,
// with optional dwell at each end and a programmable or continuous sweep count.
module sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 4,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic [WIDTH-1:0]   count,
  output logic               enb,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_lo_l, r_hi_l;
  logic [DWELL_W-1:0] r_dwell_l;
  logic [SWEEP_W-1:0] r_sweeps_l, r_sweep_cnt;
  logic [SWEEP_W-1:0] w_cnt_inc;
  logic               w_idle, w_start_req, w_start_ok, w_start_bad;
  logic               w_at_top, w_at_bot, w_sweep_end, w_last_sweep;
  logic               w_tmr_load, w_tmr_dec, w_tmr_zero;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_start_req = !rst && w_idle && start && !stop;
  assign w_start_ok  = w_start_req && (lo_lim < hi_lim);
  assign w_start_bad = w_start_req && !(lo_lim < hi_lim);

  assign w_at_top     = (count >= r_hi_l);
  assign w_at_bot     = (count <= r_lo_l);
  assign w_cnt_inc    = r_sweep_cnt + 1'b1;
  assign w_sweep_end  = (r_state == ST_DOWN) && w_at_bot && !stop;
  assign w_last_sweep = (r_sweeps_l != '0) && (w_cnt_inc == r_sweeps_l);

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    if (stop && !w_idle) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:
          if (w_start_ok)
            w_state_nxt = (count < hi_lim) ? ST_UP : ST_DOWN;
        ST_UP:
          if (w_at_top) begin
            if (r_dwell_l != '0) begin
              w_state_nxt = ST_DWELL_TOP;
              w_tmr_load  = 1'b1;
            end else begin
              w_state_nxt = ST_DOWN;
            end
          end
        ST_DWELL_TOP:
          if (w_tmr_zero) w_state_nxt = ST_DOWN;
        ST_DOWN:
          if (w_at_bot) begin
            if (w_last_sweep) begin
              w_state_nxt = ST_IDLE;
            end else if (r_dwell_l != '0) begin
              w_state_nxt = ST_DWELL_BOT;
              w_tmr_load  = 1'b1;
            end else begin
              w_state_nxt = ST_UP;
            end
          end
        ST_DWELL_BOT:
          if (w_tmr_zero) w_state_nxt = ST_UP;
        default:
          w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lo_l      <= '0;
      r_hi_l      <= '0;
      r_dwell_l   <= '0;
      r_sweeps_l  <= '0;
      r_sweep_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_lo_l      <= lo_lim;
        r_hi_l      <= hi_lim;
        r_dwell_l   <= dwell;
        r_sweeps_l  <= sweeps;
        r_sweep_cnt <= '0;
      end else if (w_sweep_end) begin
        r_sweep_cnt <= w_cnt_inc;
      end
    end
  end

  // Loaded with dwell-1 so the zero flag marks the last of exactly dwell cycles.
  assign w_tmr_dec = (r_state == ST_DWELL_TOP) || (r_state == ST_DWELL_BOT);

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_tmr_load),
    .i_load_val(r_dwell_l - 1'b1),
    .i_dec     (w_tmr_dec),
    .o_zero    (w_tmr_zero)
  );

  always_comb begin
    enb = 1'b0;
    case (r_state)
      ST_UP:   enb = (count < r_hi_l);
      ST_DOWN: enb = (count > r_lo_l);
      default: enb = 1'b0;
    endcase
    enb = enb && !stop && !rst;
  end

  assign dir       = state_dir(r_state);
  assign busy      = !w_idle;
  assign done      = !rst && w_sweep_end && w_last_sweep;
  assign err       = w_start_bad;
  assign sweep_cnt = r_sweep_cnt;

endmodule
